// File: rtl/multicycle_control_fsm.sv
// Multi-cycle RV32I main controller: sequences fetch/decode/execute/memory/writeback
// and drives datapath selects and strobes; unsupported opcodes park in a sticky trap.
module multicycle_control_fsm #(
  parameter int OPCODE_W      = 7,
  parameter int SUPPORT_IALU  = 1,
  parameter int SUPPORT_JAL   = 1,
  parameter int MEM_HANDSHAKE = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                zero,
  input  logic                mem_ready,
  output logic                pc_write,
  output logic                adr_src,
  output logic                mem_read,
  output logic                mem_write,
  output logic                ir_write,
  output logic                reg_write,
  output logic [1:0]          result_src,
  output logic [1:0]          alu_src_a,
  output logic [1:0]          alu_src_b,
  output logic [1:0]          alu_op,
  output logic                illegal,
  output logic [3:0]          state
);

  localparam logic [3:0] S_FETCH  = 4'd0;
  localparam logic [3:0] S_DECODE = 4'd1;
  localparam logic [3:0] S_MEMADR = 4'd2;
  localparam logic [3:0] S_MEMRD  = 4'd3;
  localparam logic [3:0] S_MEMWB  = 4'd4;
  localparam logic [3:0] S_MEMWR  = 4'd5;
  localparam logic [3:0] S_EXECR  = 4'd6;
  localparam logic [3:0] S_EXECI  = 4'd7;
  localparam logic [3:0] S_ALUWB  = 4'd8;
  localparam logic [3:0] S_JAL    = 4'd9;
  localparam logic [3:0] S_BEQ    = 4'd10;
  localparam logic [3:0] S_TRAP   = 4'd11;

  localparam logic [OPCODE_W-1:0] OP_LOAD  = OPCODE_W'(7'b0000011);
  localparam logic [OPCODE_W-1:0] OP_STORE = OPCODE_W'(7'b0100011);
  localparam logic [OPCODE_W-1:0] OP_RTYPE = OPCODE_W'(7'b0110011);
  localparam logic [OPCODE_W-1:0] OP_IALU  = OPCODE_W'(7'b0010011);
  localparam logic [OPCODE_W-1:0] OP_JAL   = OPCODE_W'(7'b1101111);
  localparam logic [OPCODE_W-1:0] OP_BEQ   = OPCODE_W'(7'b1100011);

  logic [3:0] state_q;
  logic [3:0] state_d;
  logic       mem_ok;
  logic       pc_update;
  logic       branch;

  assign mem_ok = (MEM_HANDSHAKE != 0) ? mem_ready : 1'b1;
  assign state  = state_q;

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_FETCH;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:  state_d = mem_ok ? S_DECODE : S_FETCH;
      S_DECODE: begin
        if (opcode == OP_LOAD || opcode == OP_STORE) state_d = S_MEMADR;
        else if (opcode == OP_RTYPE)                 state_d = S_EXECR;
        else if (opcode == OP_IALU)                  state_d = (SUPPORT_IALU != 0) ? S_EXECI : S_TRAP;
        else if (opcode == OP_JAL)                   state_d = (SUPPORT_JAL != 0) ? S_JAL : S_TRAP;
        else if (opcode == OP_BEQ)                   state_d = S_BEQ;
        else                                         state_d = S_TRAP;
      end
      S_MEMADR: state_d = (opcode == OP_STORE) ? S_MEMWR : S_MEMRD;
      S_MEMRD:  state_d = mem_ok ? S_MEMWB : S_MEMRD;
      S_MEMWB:  state_d = S_FETCH;
      S_MEMWR:  state_d = mem_ok ? S_FETCH : S_MEMWR;
      S_EXECR:  state_d = S_ALUWB;
      S_EXECI:  state_d = S_ALUWB;
      S_ALUWB:  state_d = S_FETCH;
      S_JAL:    state_d = S_ALUWB;
      S_BEQ:    state_d = S_FETCH;
      S_TRAP:   state_d = S_TRAP;
      default:  state_d = S_FETCH;
    endcase
  end

  always_comb begin
    pc_update  = 1'b0;
    branch     = 1'b0;
    adr_src    = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    result_src = 2'b00;
    alu_src_a  = 2'b00;
    alu_src_b  = 2'b00;
    alu_op     = 2'b00;
    illegal    = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_read   = 1'b1;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        ir_write   = mem_ok;
        pc_update  = mem_ok;
      end
      S_DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
      end
      S_MEMADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
      end
      S_MEMRD: begin
        adr_src  = 1'b1;
        mem_read = 1'b1;
      end
      S_MEMWB: begin
        result_src = 2'b01;
        reg_write  = 1'b1;
      end
      S_MEMWR: begin
        adr_src   = 1'b1;
        mem_write = 1'b1;
      end
      S_EXECR: begin
        alu_src_a = 2'b10;
        alu_op    = 2'b10;
      end
      S_EXECI: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        alu_op    = 2'b10;
      end
      S_ALUWB:  reg_write = 1'b1;
      S_JAL: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        pc_update = 1'b1;
      end
      S_BEQ: begin
        alu_src_a = 2'b10;
        alu_op    = 2'b01;
        branch    = 1'b1;
      end
      S_TRAP:   illegal = 1'b1;
      default:  ;
    endcase
    pc_write = pc_update | (branch & zero);
    // Architectural side effects are suppressed for the whole reset cycle.
    if (rst) begin
      pc_write  = 1'b0;
      ir_write  = 1'b0;
      reg_write = 1'b0;
      mem_read  = 1'b0;
      mem_write = 1'b0;
    end
  end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Bench for multicycle_control_fsm: vector table, directed corner sequences and a
// randomized instruction stream checked against an instruction-level model.
module tb_multicycle_control_fsm;

  localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011;
  localparam logic [6:0] IA = 7'b0010011, JL = 7'b1101111, BQ = 7'b1100011;

  // {pc_write, adr_src, mem_read, mem_write, ir_write, reg_write, result_src, alu_src_a, alu_src_b, alu_op, illegal}
  localparam logic [14:0] O_FETCH  = 15'b1_0_1_0_1_0_10_00_10_00_0;
  localparam logic [14:0] O_FETCHW = 15'b0_0_1_0_0_0_10_00_10_00_0;
  localparam logic [14:0] O_FETCHR = 15'b0_0_0_0_0_0_10_00_10_00_0;
  localparam logic [14:0] O_DEC    = 15'b0_0_0_0_0_0_00_01_01_00_0;
  localparam logic [14:0] O_MADR   = 15'b0_0_0_0_0_0_00_10_01_00_0;
  localparam logic [14:0] O_MRD    = 15'b0_1_1_0_0_0_00_00_00_00_0;
  localparam logic [14:0] O_MWB    = 15'b0_0_0_0_0_1_01_00_00_00_0;
  localparam logic [14:0] O_MWR    = 15'b0_1_0_1_0_0_00_00_00_00_0;
  localparam logic [14:0] O_EXR    = 15'b0_0_0_0_0_0_00_10_00_10_0;
  localparam logic [14:0] O_EXI    = 15'b0_0_0_0_0_0_00_10_01_10_0;
  localparam logic [14:0] O_AWB    = 15'b0_0_0_0_0_1_00_00_00_00_0;
  localparam logic [14:0] O_JAL    = 15'b1_0_0_0_0_0_00_01_10_00_0;
  localparam logic [14:0] O_BEQT   = 15'b1_0_0_0_0_0_00_10_00_01_0;
  localparam logic [14:0] O_BEQN   = 15'b0_0_0_0_0_0_00_10_00_01_0;
  localparam logic [14:0] O_TRAP   = 15'b0_0_0_0_0_0_00_00_00_00_1;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [6:0] opcode = 7'd0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b1;

  logic a_pc_write, a_adr_src, a_mem_read, a_mem_write, a_ir_write, a_reg_write, a_illegal;
  logic [1:0] a_result_src, a_alu_src_a, a_alu_src_b, a_alu_op;
  logic [3:0] a_state;
  logic b_pc_write, b_adr_src, b_mem_read, b_mem_write, b_ir_write, b_reg_write, b_illegal;
  logic [1:0] b_result_src, b_alu_src_a, b_alu_src_b, b_alu_op;
  logic [3:0] b_state;

  always #5 clk = ~clk;

  multicycle_control_fsm dut_a (
    .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .pc_write(a_pc_write), .adr_src(a_adr_src), .mem_read(a_mem_read), .mem_write(a_mem_write),
    .ir_write(a_ir_write), .reg_write(a_reg_write), .result_src(a_result_src),
    .alu_src_a(a_alu_src_a), .alu_src_b(a_alu_src_b), .alu_op(a_alu_op),
    .illegal(a_illegal), .state(a_state)
  );

  // Reduced configuration: no I-ALU, no JAL, memory never waits.
  multicycle_control_fsm #(.SUPPORT_IALU(0), .SUPPORT_JAL(0), .MEM_HANDSHAKE(0)) dut_b (
    .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .pc_write(b_pc_write), .adr_src(b_adr_src), .mem_read(b_mem_read), .mem_write(b_mem_write),
    .ir_write(b_ir_write), .reg_write(b_reg_write), .result_src(b_result_src),
    .alu_src_a(b_alu_src_a), .alu_src_b(b_alu_src_b), .alu_op(b_alu_op),
    .illegal(b_illegal), .state(b_state)
  );

  wire [14:0] a_out = {a_pc_write, a_adr_src, a_mem_read, a_mem_write, a_ir_write, a_reg_write,
                       a_result_src, a_alu_src_a, a_alu_src_b, a_alu_op, a_illegal};
  wire b_strobes = b_pc_write | b_mem_read | b_mem_write | b_ir_write | b_reg_write;
  wire a_strobes_nr = a_pc_write | a_mem_write | a_reg_write | a_mem_read | a_ir_write;

  typedef struct {
    logic        rst;
    logic [6:0]  op;
    logic        z;
    logic        mr;
    logic [3:0]  st;
    logic [14:0] out;
  } vec_t;

  typedef struct {
    logic [3:0] st;
    logic       mr;
  } step_t;

  vec_t  vt[$];
  step_t q[$];
  int    n_cmp = 0;
  int    n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic add(input logic r, input logic [6:0] op, input logic z, input logic mr,
                     input logic [3:0] st, input logic [14:0] o);
    vec_t v;
    v.rst = r; v.op = op; v.z = z; v.mr = mr; v.st = st; v.out = o;
    vt.push_back(v);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic reset_all;
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic push_steps(input logic [3:0] st, input int waits);
    step_t s;
    for (int i = 0; i < waits; i++) begin
      s.st = st; s.mr = 1'b0; q.push_back(s);
    end
    s.st = st; s.mr = 1'b1; q.push_back(s);
  endtask

  task automatic push_one(input logic [3:0] st);
    step_t s;
    s.st = st; s.mr = 1'($urandom_range(0, 1));
    q.push_back(s);
  endtask

  int cls, wf, wm, rw_seen, bad_cnt, trap_miss;
  int c_rw, c_mw, c_mr, c_pcw, c_ir, c_il;
  int e_rw, e_mw, e_mr, e_pcw;
  logic z_r;
  logic [3:0] b_seq [6];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    tick();
    tick();

    // Vector table: one row per clock, outputs checked before the edge.
    add(1, RT, 0, 1, 0, O_FETCHR);
    add(0, RT, 1, 1, 0, O_FETCH); add(0, RT, 1, 1, 1, O_DEC);
    add(0, RT, 1, 1, 6, O_EXR);   add(0, RT, 1, 1, 8, O_AWB);
    add(0, LW, 0, 1, 0, O_FETCH); add(0, LW, 0, 1, 1, O_DEC); add(0, LW, 0, 1, 2, O_MADR);
    add(0, LW, 0, 0, 3, O_MRD);   add(0, LW, 0, 0, 3, O_MRD); add(0, LW, 0, 1, 3, O_MRD);
    add(0, LW, 0, 1, 4, O_MWB);
    add(0, SW, 0, 0, 0, O_FETCHW); add(0, SW, 0, 1, 0, O_FETCH); add(0, SW, 0, 1, 1, O_DEC);
    add(0, SW, 0, 1, 2, O_MADR);   add(0, SW, 0, 0, 5, O_MWR);   add(0, SW, 0, 1, 5, O_MWR);
    add(0, BQ, 1, 1, 0, O_FETCH); add(0, BQ, 1, 1, 1, O_DEC); add(0, BQ, 1, 1, 10, O_BEQT);
    add(0, BQ, 0, 1, 0, O_FETCH); add(0, BQ, 0, 1, 1, O_DEC); add(0, BQ, 0, 1, 10, O_BEQN);
    add(0, JL, 0, 1, 0, O_FETCH); add(0, JL, 0, 1, 1, O_DEC);
    add(0, JL, 0, 1, 9, O_JAL);   add(0, JL, 0, 1, 8, O_AWB);
    add(0, IA, 0, 1, 0, O_FETCH); add(0, IA, 0, 1, 1, O_DEC);
    add(0, IA, 0, 1, 7, O_EXI);   add(0, IA, 0, 1, 8, O_AWB);
    add(0, 7'd0, 0, 1, 0, O_FETCH); add(0, 7'd0, 0, 1, 1, O_DEC);
    add(0, 7'd0, 1, 1, 11, O_TRAP); add(0, 7'd0, 1, 0, 11, O_TRAP);
    add(1, 7'd0, 0, 1, 11, O_TRAP);
    add(0, RT, 0, 1, 0, O_FETCH);

    foreach (vt[i]) begin
      rst = vt[i].rst; opcode = vt[i].op; zero = vt[i].z; mem_ready = vt[i].mr;
      #1;
      chk($sformatf("vec%0d state", i), 32'(a_state), 32'(vt[i].st));
      chk($sformatf("vec%0d outputs", i), 32'(a_out), 32'(vt[i].out));
      @(posedge clk);
      #1;
    end

    // Reset asserted while a load waits in MEMRD.
    reset_all();
    opcode = LW; mem_ready = 1'b1; zero = 1'b0; rw_seen = 0;
    repeat (3) begin
      #1;
      rw_seen += int'(a_reg_write);
      tick();
    end
    #1;
    chk("rst_memrd reached MEMRD", 32'(a_state), 32'd3);
    mem_ready = 1'b0; rst = 1'b1;
    #1;
    rw_seen += int'(a_reg_write);
    chk("rst_memrd mem_read forced low", 32'(a_mem_read), 32'd0);
    tick();
    rst = 1'b0;
    #1;
    chk("rst_memrd state", 32'(a_state), 32'd0);
    chk("rst_memrd illegal", 32'(a_illegal), 32'd0);
    chk("rst_memrd reg_write pulses", 32'(rw_seen), 32'd0);

    // Illegal opcode: trap holds with no side effects until reset.
    reset_all();
    opcode = 7'd0; mem_ready = 1'b1;
    tick(); tick();
    bad_cnt = 0; trap_miss = 0;
    for (int i = 0; i < 12; i++) begin
      mem_ready = 1'($urandom_range(0, 1)); zero = 1'($urandom_range(0, 1));
      #1;
      bad_cnt += int'(a_strobes_nr);
      if (a_state != 4'd11 || a_illegal != 1'b1) trap_miss++;
      tick();
    end
    chk("trap strobe cycles", 32'(bad_cnt), 32'd0);
    chk("trap not held", 32'(trap_miss), 32'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("trap exit state", 32'(a_state), 32'd0);
    chk("trap exit illegal", 32'(a_illegal), 32'd0);

    // Reduced config: JAL traps and stays trapped.
    reset_all();
    opcode = JL; mem_ready = 1'b1;
    tick(); tick();
    bad_cnt = 0; trap_miss = 0;
    for (int i = 0; i < 12; i++) begin
      #1;
      bad_cnt += int'(b_strobes);
      if (b_state != 4'd11 || b_illegal != 1'b1) trap_miss++;
      tick();
    end
    chk("nojal trap not held", 32'(trap_miss), 32'd0);
    chk("nojal strobe cycles", 32'(bad_cnt), 32'd0);

    // Reduced config: memory states ignore mem_ready.
    reset_all();
    opcode = LW; mem_ready = 1'b0;
    b_seq[0] = 4'd0; b_seq[1] = 4'd1; b_seq[2] = 4'd2;
    b_seq[3] = 4'd3; b_seq[4] = 4'd4; b_seq[5] = 4'd0;
    for (int i = 0; i < 6; i++) begin
      #1;
      chk($sformatf("nohs lw step%0d", i), 32'(b_state), 32'(b_seq[i]));
      if (i == 0) chk("nohs fetch ir_write", 32'(b_ir_write), 32'd1);
      tick();
    end

    // Reduced config: I-ALU opcode traps.
    reset_all();
    opcode = IA; mem_ready = 1'b1;
    tick(); tick();
    #1;
    chk("noialu trap", 32'(b_state), 32'd11);
    chk("noialu illegal", 32'(b_illegal), 32'd1);
    tick();

    // Random instruction stream on the full configuration.
    reset_all();
    for (int n = 0; n < 150; n++) begin
      cls = $urandom_range(0, 5);
      wf  = $urandom_range(0, 2);
      wm  = $urandom_range(0, 2);
      z_r = 1'($urandom_range(0, 1));
      q.delete();
      push_steps(4'd0, wf);
      push_one(4'd1);
      case (cls)
        0: begin opcode = LW; push_one(4'd2); push_steps(4'd3, wm); push_one(4'd4); end
        1: begin opcode = SW; push_one(4'd2); push_steps(4'd5, wm); end
        2: begin opcode = RT; push_one(4'd6); push_one(4'd8); end
        3: begin opcode = IA; push_one(4'd7); push_one(4'd8); end
        4: begin opcode = JL; push_one(4'd9); push_one(4'd8); end
        default: begin opcode = BQ; push_one(4'd10); end
      endcase
      e_rw  = (cls <= 4 && cls != 1) ? 1 : 0;
      e_mw  = (cls == 1) ? wm + 1 : 0;
      e_mr  = wf + 1 + ((cls == 0) ? wm + 1 : 0);
      e_pcw = 1 + ((cls == 4) ? 1 : 0) + ((cls == 5 && z_r) ? 1 : 0);
      c_rw = 0; c_mw = 0; c_mr = 0; c_pcw = 0; c_ir = 0; c_il = 0;
      zero = z_r;
      foreach (q[k]) begin
        mem_ready = q[k].mr;
        #1;
        chk($sformatf("rand%0d cyc%0d state", n, k), 32'(a_state), 32'(q[k].st));
        c_rw += int'(a_reg_write); c_mw += int'(a_mem_write); c_mr += int'(a_mem_read);
        c_pcw += int'(a_pc_write); c_ir += int'(a_ir_write); c_il += int'(a_illegal);
        tick();
      end
      mem_ready = 1'b0;
      #1;
      chk($sformatf("rand%0d back to fetch", n), 32'(a_state), 32'd0);
      chk($sformatf("rand%0d reg_write", n), 32'(c_rw), 32'(e_rw));
      chk($sformatf("rand%0d mem_write", n), 32'(c_mw), 32'(e_mw));
      chk($sformatf("rand%0d mem_read", n), 32'(c_mr), 32'(e_mr));
      chk($sformatf("rand%0d pc_write", n), 32'(c_pcw), 32'(e_pcw));
      chk($sformatf("rand%0d ir_write", n), 32'(c_ir), 32'd1);
      chk($sformatf("rand%0d illegal", n), 32'(c_il), 32'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/multicycle_control_fsm.md
Name: multicycle_control_fsm

Overview:
Multi-cycle main controller for the RV32I datapath, replacing the single-cycle opcode decoder. It sequences each instruction through fetch, decode, execute, memory and writeback states, and drives the datapath multiplexer selects and write enables per state. It adds a memory ready handshake and parametrised support for I-type ALU and JAL. Unsupported opcodes drive a sticky illegal-instruction trap.

Parameters:
OPCODE_W, 7, opcode field width (fixed by the ISA; exposed for lint and bench use only)
SUPPORT_IALU, 1, 1 = decode opcode 0010011 (I-type ALU); 0 = that opcode traps
SUPPORT_JAL, 1, 1 = decode opcode 1101111 (JAL); 0 = that opcode traps
MEM_HANDSHAKE, 1, 1 = memory states wait for mem_ready; 0 = mem_ready is treated as constant 1

Ports:
clk  in  1  single clock; all state changes on the rising edge
rst  in  1  synchronous, active-high reset
opcode  in  OPCODE_W  instr[6:0] from the instruction register; stable from DECODE until the next FETCH
zero  in  1  ALU zero flag
mem_ready  in  1  memory access completes this cycle
pc_write  out  1  PC load enable
adr_src  out  1  memory address select: 0 = PC, 1 = ALUOut
mem_read  out  1  memory read strobe
mem_write  out  1  memory write strobe
ir_write  out  1  instruction register and oldPC load enable
reg_write  out  1  register file write enable
result_src  out  2  result mux: 00 = ALUOut, 01 = mem data, 10 = ALU result
alu_src_a  out  2  ALU A select: 00 = PC, 01 = oldPC, 10 = rs1
alu_src_b  out  2  ALU B select: 00 = rs2, 01 = imm, 10 = constant 4
alu_op  out  2  ALU op class: 00 = add, 01 = sub/compare, 10 = funct-decoded
illegal  out  1  sticky illegal-opcode flag
state  out  4  current state encoding, for debug and bench visibility

Behaviour:
- State encoding: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXECR=6, EXECI=7, ALUWB=8, JAL=9, BEQ=10, TRAP=11. Codes 12-15 go to FETCH on the next edge.
- Reset: on any edge with rst=1, state becomes FETCH and illegal becomes 0. This applies in any state, including memory wait and TRAP.
- While rst=1, pc_write, ir_write, reg_write, mem_read and mem_write are forced to 0.
- Outputs are Moore, decoded from state, except that pc_write = pc_update | (branch & zero).
- Any select or alu_op not listed for a state is 00. All strobes not listed are 0.
- FETCH: mem_read=1, adr_src=0, alu_src_a=00, alu_src_b=10, alu_op=00, result_src=10.
  - ir_write = pc_update = mem_ready.
  - Stay in FETCH while mem_ready=0; go to DECODE when mem_ready=1.
- DECODE: alu_src_a=01, alu_src_b=01, alu_op=00 (precomputes the branch/JAL target into ALUOut). Next state by opcode:
  - 0000011 or 0100011 -> MEMADR
  - 0110011 -> EXECR
  - 0010011 -> EXECI if SUPPORT_IALU=1, else TRAP
  - 1101111 -> JAL if SUPPORT_JAL=1, else TRAP
  - 1100011 -> BEQ
  - any other opcode -> TRAP
- MEMADR: alu_src_a=10, alu_src_b=01, alu_op=00. Next state is MEMRD for a load, MEMWR for a store.
- MEMRD: adr_src=1, mem_read=1. Hold while mem_ready=0; go to MEMWB when mem_ready=1.
- MEMWB: result_src=01, reg_write=1 -> FETCH.
- MEMWR: adr_src=1, mem_write=1, held high while waiting. Go to FETCH when mem_ready=1.
- EXECR: alu_src_a=10, alu_src_b=00, alu_op=10 -> ALUWB.
- EXECI: alu_src_a=10, alu_src_b=01, alu_op=10 -> ALUWB.
- ALUWB: result_src=00, reg_write=1 -> FETCH.
- JAL: alu_src_a=01, alu_src_b=10, alu_op=00, result_src=00, pc_update=1 (PC <- target). Next state ALUWB, which writes rd = oldPC+4.
- BEQ: alu_src_a=10, alu_src_b=00, alu_op=01, result_src=00, branch=1 (pc_write=zero) -> FETCH.
- TRAP: illegal=1 and all strobes 0. Remains in TRAP until reset.
- Cycle counts with zero memory wait: lw 5, sw 4, R-type 4, I-ALU 4, jal 4, beq 3. Each cycle with mem_ready=0 in FETCH, MEMRD or MEMWR adds one cycle.
- With MEM_HANDSHAKE=0, every memory state completes in one cycle.

Test Plan:
- Reset mid-MEMRD (rst=1 for one edge while mem_ready=0) -> state=0 next cycle, illegal=0, no reg_write has pulsed.
- R-type 0110011 with mem_ready=1 -> state sequence 0,1,6,8,0; reg_write=1 only in state 8; alu_op=10 in state 6.
- lw 0000011 with mem_ready low for 2 cycles in MEMRD -> states 0,1,2,3,3,3,4,0; mem_read held through all three state-3 cycles; result_src=01 in state 4.
- beq 1100011 with zero=1 then zero=0 -> pc_write=1 in BEQ for the first case, 0 for the second; 3 cycles each.
- jal 1101111 with SUPPORT_JAL=1 -> states 0,1,9,8,0 with pc_write=1 in state 9; with SUPPORT_JAL=0 -> state 11, illegal=1, stays there for 10+ cycles.
- Opcode 0000000 -> TRAP; mem_write, reg_write and pc_write stay 0 until rst=1, then state returns to FETCH.
